mem_responder: RTL and testbench

- Data-memory responder: the memory end of the CPU's load/store interface.
- Accepts one request at a time over a valid/ready handshake and holds a doubleword-organised storage array.
- Performs byte-lane-masked writes and lane-aligned reads after a programmable latency, then returns a response over a second valid/ready handshake.
- Replaces the zero-latency combinational memory, so the pipeline can be exercised against realistic, stalling memory.

---
 rtl/mem_responder.sv | 213 +++++++++++++++++++++
 tb/tb_mem_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Data-memory responder: one outstanding load/store, byte-lane masked storage, response after LATENCY cycles.
// Optional trace: define MEM_RESPONDER_TRACE_EN to print one line per response handshake.
module mem_responder #(
    parameter int          DATA_WIDTH = 64,
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [63:0]           req_addr,
    input  logic                  req_wen,
    input  logic [1:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);
    localparam int         BYTES  = DATA_WIDTH / 8;
    localparam int         OFF_W  = $clog2(BYTES);
    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam int         IDX_HI = DEPTH_LOG2 + OFF_W - 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    req_ready_q, req_ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [OFF_W-1:0]        off_q, off_d;
    logic [1:0]              size_q, size_d;
    logic                    wen_q, wen_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic [DATA_WIDTH-1:0]   mem_array [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word_q;

    logic                    accept;
    logic [63:0]             req_off;
    logic [OFF_W-1:0]        req_align_mask;
    logic                    req_oor;
    logic                    req_mis;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    mem_we;
    logic [BYTES-1:0]        lane_mask;
    logic [BYTES-1:0]        byte_en;
    logic [DATA_WIDTH-1:0]   lane_mask_ext;
    logic [DATA_WIDTH-1:0]   wdata_shift;
    logic [DATA_WIDTH-1:0]   merged_word;
    logic [DATA_WIDTH-1:0]   load_data;

    // Request decode happens at accept time so only compact indices/flags are held.
    assign accept         = (state_q == IDLE) && req_valid;
    assign req_off        = req_addr - BASE_ADDR;
    assign req_align_mask = OFF_W'((32'd1 << req_size) - 32'd1);
    assign req_oor        = (req_addr < BASE_ADDR) || (req_off[63:IDX_HI+1] != '0);
    assign req_mis        = (req_off[OFF_W-1:0] & req_align_mask) != '0;

    // The read port is addressed straight from the request on the accepting edge,
    // so the word is already registered by EXEC even when LATENCY is 1.
    assign rd_idx = accept ? req_off[IDX_HI:OFF_W] : idx_q;
    assign mem_we = (state_q == EXEC) && wen_q && !err_q && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[idx_q] <= merged_word;
        end
        rd_word_q <= mem_array[rd_idx];
    end

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (b < (1 << size_q)) begin
                lane_mask[b] = 1'b1;
            end
        end
    end

    assign byte_en     = lane_mask << off_q;
    assign wdata_shift = wdata_q << {off_q, 3'b000};
    assign load_data   = (rd_word_q >> {off_q, 3'b000}) & lane_mask_ext;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            assign lane_mask_ext[8*gi +: 8] = {8{lane_mask[gi]}};
            assign merged_word[8*gi +: 8]   = byte_en[gi] ? wdata_shift[8*gi +: 8]
                                                          : rd_word_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        idx_d        = idx_q;
        off_d        = off_q;
        size_d       = size_q;
        wen_d        = wen_q;
        err_d        = err_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    idx_d       = req_off[IDX_HI:OFF_W];
                    off_d       = req_off[OFF_W-1:0];
                    size_d      = req_size;
                    wen_d       = req_wen;
                    wdata_d     = req_wdata;
                    err_d       = req_oor || req_mis;
                    cnt_d       = LAT_M1;
                    req_ready_d = 1'b0;
                    state_d     = (LATENCY > 1) ? WAIT : EXEC;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                resp_err_d   = err_q;
                resp_rdata_d = (err_q || wen_q) ? '0 : load_data;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            idx_q        <= '0;
            off_q        <= '0;
            size_q       <= '0;
            wen_q        <= 1'b0;
            err_q        <= 1'b0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            idx_q        <= idx_d;
            off_q        <= off_d;
            size_q       <= size_d;
            wen_q        <= wen_d;
            err_q        <= err_d;
            wdata_q      <= wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

`ifdef MEM_RESPONDER_TRACE_EN
    logic [63:0]           trace_addr_q;
    logic [DATA_WIDTH-1:0] trace_data_q;

    // Stores report the merged word that was committed, loads the returned data.
    always_ff @(posedge clk) begin
        if (rst) begin
            trace_addr_q <= '0;
            trace_data_q <= '0;
        end else begin
            if (accept) begin
                trace_addr_q <= req_addr;
            end
            if (state_q == EXEC) begin
                trace_data_q <= mem_we ? merged_word : resp_rdata_d;
            end
            if ((state_q == RESP) && resp_ready) begin
                $display("mem %s addr=%h size=%0d data=%h err=%0d",
                         wen_q ? "W" : "R", trace_addr_q, size_q, trace_data_q, resp_err_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a LATENCY=2 and a LATENCY=1 instance share the request bus.
module tb_mem_responder;
    localparam logic [63:0] BASE = 64'h8000_0000;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_ready;

    logic        l2_req_valid, l1_req_valid;
    logic        l2_req_ready, l1_req_ready;
    logic        l2_resp_valid, l1_resp_valid;
    logic [63:0] l2_resp_rdata, l1_resp_rdata;
    logic        l2_resp_err, l1_resp_err;

    logic        o_req_ready, o_resp_valid, o_resp_err;
    logic [63:0] o_resp_rdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb_q[$];
    logic [63:0] shadow [int];
    logic [63:0] last_rdata;
    logic        last_err;

    always #5 clk = ~clk;

    assign l2_req_valid = req_valid & ~sel;
    assign l1_req_valid = req_valid & sel;
    assign o_req_ready  = sel ? l1_req_ready  : l2_req_ready;
    assign o_resp_valid = sel ? l1_resp_valid : l2_resp_valid;
    assign o_resp_rdata = sel ? l1_resp_rdata : l2_resp_rdata;
    assign o_resp_err   = sel ? l1_resp_err   : l2_resp_err;

    mem_responder #(.DATA_WIDTH(64), .DEPTH_LOG2(12), .BASE_ADDR(BASE), .LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(l2_req_valid), .req_ready(l2_req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(l2_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(l2_resp_rdata), .resp_err(l2_resp_err)
    );

    mem_responder #(.DATA_WIDTH(64), .DEPTH_LOG2(12), .BASE_ADDR(BASE), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(l1_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference memory: per-instance shadow words, byte-granular update/extract.
    task automatic predict(input logic [63:0] addr, input logic wen, input logic [1:0] size,
                           input logic [63:0] wdata, output logic [63:0] rd, output logic err);
        logic [63:0] off;
        logic [63:0] w;
        int          n;
        int          o;
        int          key;
        n   = 1 << size;
        o   = int'(addr[2:0]);
        off = addr - BASE;
        err = (addr < BASE) || (off >= 64'h8000) || ((o % n) != 0);
        rd  = 64'h0;
        if (!err) begin
            key = (sel ? 65536 : 0) + int'(off[14:3]);
            w   = shadow.exists(key) ? shadow[key] : 64'h0;
            for (int b = 0; b < n; b++) begin
                if (wen) w[8*(o+b) +: 8] = wdata[8*b +: 8];
                else     rd[8*b +: 8]    = w[8*(o+b) +: 8];
            end
            if (wen) shadow[key] = w;
        end
    endtask

    // Called and returns at posedge+1 with the selected instance idle.
    task automatic xact(input logic [63:0] addr, input logic wen, input logic [1:0] size,
                        input logic [63:0] wdata, input int hold, input string tag);
        exp_t e;
        int   n;
        int   lat;
        int   exp_lat;
        exp_lat = sel ? 1 : 2;
        predict(addr, wen, size, wdata, e.rdata, e.err);
        sb_q.push_back(e);
        req_addr  = addr;
        req_wen   = wen;
        req_size  = size;
        req_wdata = wdata;
        req_valid = 1'b1;
        n = 0;
        while (!o_req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".req_ready"}, 64'(o_req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_addr   = {$urandom, $urandom};
        req_wdata  = {$urandom, $urandom};
        req_wen    = ~wen;
        req_size   = 2'($urandom_range(0, 3));
        resp_ready = (hold == 0);
        lat = 0;
        while (!o_resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            check({tag, ".hold_valid"}, 64'(o_resp_valid), 64'd1);
            check({tag, ".hold_rdata"}, o_resp_rdata, sb_q[0].rdata);
            check({tag, ".hold_err"}, 64'(o_resp_err), 64'(sb_q[0].err));
            check({tag, ".hold_req_ready"}, 64'(o_req_ready), 64'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        e = sb_q.pop_front();
        check({tag, ".rdata"}, o_resp_rdata, e.rdata);
        check({tag, ".err"}, 64'(o_resp_err), 64'(e.err));
        last_rdata = o_resp_rdata;
        last_err   = o_resp_err;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, ".post_valid"}, 64'(o_resp_valid), 64'd0);
        check({tag, ".post_req_ready"}, 64'(o_req_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] addr;
        int          sz;
        int          o;
        rst        = 1'b1;
        sel        = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 64'h0;
        req_wen    = 1'b0;
        req_size   = 2'd0;
        req_wdata  = 64'h0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.req_ready", 64'(l2_req_ready), 64'd1);
        check("rst.resp_valid", 64'(l2_resp_valid), 64'd0);
        check("rst.resp_rdata", l2_resp_rdata, 64'd0);
        check("rst.resp_err", 64'(l2_resp_err), 64'd0);
        check("rst.l1_req_ready", 64'(l1_req_ready), 64'd1);
        check("rst.l1_resp_valid", 64'(l1_resp_valid), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        xact(BASE, 1'b1, 2'd3, 64'h1122334455667788, 0, "st_d");
        xact(BASE, 1'b0, 2'd3, 64'h0, 0, "ld_d");
        check("ld_d.literal", last_rdata, 64'h1122334455667788);
        xact(BASE + 3, 1'b1, 2'd0, 64'hDEAD_BEEF_CAFE_00AB, 0, "st_b");
        xact(BASE, 1'b0, 2'd3, 64'h0, 0, "ld_merge");
        check("ld_merge.literal", last_rdata, 64'h11223344AB667788);
        xact(BASE + 2, 1'b0, 2'd1, 64'h0, 0, "ld_h");
        check("ld_h.literal", last_rdata, 64'h0000_0000_0000_AB66);
        xact(BASE + 2, 1'b0, 2'd2, 64'h0, 0, "ld_w_misal");
        check("ld_w_misal.literal_err", 64'(last_err), 64'd1);
        xact(BASE + 64'h8000, 1'b1, 2'd3, 64'hFFFF_0000_FFFF_0000, 0, "st_oor");
        check("st_oor.literal_err", 64'(last_err), 64'd1);
        xact(BASE - 8, 1'b0, 2'd3, 64'h0, 0, "ld_below");
        xact(BASE, 1'b0, 2'd3, 64'h0, 0, "reread");
        xact(BASE + 64'h7FF8, 1'b1, 2'd3, 64'hA5A5_5A5A_0F0F_F0F0, 0, "st_last");
        xact(BASE + 64'h7FFC, 1'b0, 2'd2, 64'h0, 0, "ld_last_w");
        xact(BASE, 1'b0, 2'd3, 64'h0, 5, "bp");

        // Abort a store with reset during its WAIT cycle; the old contents must survive.
        xact(BASE + 16, 1'b1, 2'd3, 64'h0102_0304_0506_0708, 0, "st_pre");
        req_addr  = BASE + 16;
        req_wen   = 1'b1;
        req_size  = 2'd3;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.resp_valid", 64'(l2_resp_valid), 64'd0);
        check("abort.req_ready", 64'(l2_req_ready), 64'd1);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort.idle_valid", 64'(l2_resp_valid), 64'd0);
        end
        xact(BASE + 16, 1'b0, 2'd3, 64'h0, 0, "ld_after_abort");
        check("ld_after_abort.literal", last_rdata, 64'h0102_0304_0506_0708);

        xact(BASE + 8, 1'b1, 2'd3, {$urandom, $urandom}, 0, "st_w1");
        for (int i = 0; i < 10; i++) begin
            sz   = int'($urandom_range(0, 3));
            o    = (int'($urandom_range(0, 7)) >> sz) << sz;
            addr = BASE + 64'(8 * int'($urandom_range(0, 1)) + o);
            xact(addr, (i % 2) == 0, 2'(sz), {$urandom, $urandom}, 0, "rnd");
        end

        sel = 1'b1;
        xact(BASE, 1'b1, 2'd3, 64'hCAFE_F00D_1234_5678, 0, "l1_st");
        xact(BASE, 1'b0, 2'd3, 64'h0, 0, "l1_ld");
        xact(BASE + 4, 1'b1, 2'd2, 64'h0000_0000_8765_4321, 0, "l1_st_w");
        xact(BASE + 4, 1'b0, 2'd1, 64'h0, 0, "l1_ld_h");
        xact(BASE, 1'b0, 2'd3, 64'h0, 0, "l1_ld_d");
        xact(BASE + 1, 1'b0, 2'd1, 64'h0, 0, "l1_misal");
        xact(BASE, 1'b0, 2'd3, 64'h0, 3, "l1_bp");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
